exu_sequencer: RTL and testbench

- Multi-cycle control FSM for the RV64 core: sequences instruction fetch, decode, execute, memory and writeback around the existing execute unit.
- Owns the architectural PC, the instruction register, register-file write enable and the halt/trap status.
- Sits between the instruction/data memory handshakes, the decoder outputs and the EXU result/next-PC outputs.

---
 rtl/exu_sequencer.sv | 140 ++++++++++++++
 tb/tb_exu_sequencer.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/exu_sequencer.sv
// exu_sequencer: multi-cycle fetch/decode/exec/mem/wb control FSM for the RV64 core.
// Owns pc, the instruction register, rf write strobe, retire counter and halt/trap status.
module exu_sequencer #(
    parameter int              XLEN     = 64,
    parameter logic [XLEN-1:0] RESET_PC = 64'h8000_0000,
    parameter int              TIMEOUT  = 255
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [31:0]     imem_rdata,
    output logic [31:0]     inst,
    input  logic            dec_inval,
    input  logic            dec_ebreak,
    input  logic            dec_mem,
    input  logic            dec_jump,
    input  logic            dec_wen,
    input  logic [XLEN-1:0] exu_dnpc,
    output logic            dmem_req,
    input  logic            dmem_ack,
    output logic            rf_wen,
    output logic [XLEN-1:0] pc,
    output logic            halt,
    output logic            trap,
    output logic [1:0]      trap_cause,
    output logic [63:0]     instret
);
    typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT, TRAP} state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d, tgt_q, tgt_d;
    logic [31:0]     inst_q, inst_d;
    logic [7:0]      cnt_q, cnt_d;
    logic [1:0]      cause_q, cause_d;
    logic [63:0]     instret_q, instret_d;
    logic            imem_req_q, dmem_req_q;

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        tgt_d     = tgt_q;
        inst_d    = inst_q;
        cnt_d     = cnt_q;
        cause_d   = cause_q;
        instret_d = instret_q;
        case (state_q)
            FETCH: begin
                if (imem_req_q && imem_ack) begin
                    inst_d  = imem_rdata;
                    state_d = DECODE;
                end else if (imem_req_q) begin
                    if (cnt_q == 8'(TIMEOUT)) begin
                        state_d = TRAP;
                        cause_d = 2'd3;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            end
            DECODE: begin
                if (dec_inval) begin
                    state_d = TRAP;
                    cause_d = 2'd1;
                end else if (dec_ebreak) begin
                    state_d   = HALT;
                    instret_d = instret_q + 64'd1;
                end else begin
                    state_d = EXEC;
                end
            end
            EXEC: begin
                // bit0 of a jalr target is architecturally cleared; bit1 set means misaligned
                tgt_d = exu_dnpc & ~XLEN'(1);
                if (dec_jump && exu_dnpc[1]) begin
                    state_d = TRAP;
                    cause_d = 2'd2;
                end else begin
                    state_d = dec_mem ? MEM : WB;
                    cnt_d   = 8'd0;
                end
            end
            MEM: begin
                if (dmem_req_q && dmem_ack) begin
                    state_d = WB;
                end else if (dmem_req_q) begin
                    if (cnt_q == 8'(TIMEOUT)) begin
                        state_d = TRAP;
                        cause_d = 2'd3;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            end
            WB: begin
                pc_d      = dec_jump ? tgt_q : pc_q + XLEN'(4);
                instret_d = instret_q + 64'd1;
                cnt_d     = 8'd0;
                state_d   = FETCH;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= FETCH;
            pc_q       <= RESET_PC;
            tgt_q      <= '0;
            inst_q     <= '0;
            cnt_q      <= '0;
            cause_q    <= '0;
            instret_q  <= '0;
            imem_req_q <= 1'b0;
            dmem_req_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            tgt_q      <= tgt_d;
            inst_q     <= inst_d;
            cnt_q      <= cnt_d;
            cause_q    <= cause_d;
            instret_q  <= instret_d;
            imem_req_q <= state_d == FETCH;
            dmem_req_q <= state_d == MEM;
        end
    end

    assign imem_req   = imem_req_q;
    assign dmem_req   = dmem_req_q;
    assign imem_addr  = pc_q;
    assign pc         = pc_q;
    assign inst       = inst_q;
    assign rf_wen     = (state_q == WB) && dec_wen;
    assign halt       = state_q == HALT;
    assign trap       = state_q == TRAP;
    assign trap_cause = cause_q;
    assign instret    = instret_q;
endmodule

// File: tb/tb_exu_sequencer.sv
// tb_exu_sequencer: directed stimulus with a scoreboard of expected retire/halt/trap events,
// popped by a negedge monitor whenever the DUT shows one.
module tb_exu_sequencer;
    logic        clk = 1'b0, rst = 1'b0;
    logic        imem_req, imem_ack = 1'b0, dmem_req, dmem_ack = 1'b0;
    logic [63:0] imem_addr, exu_dnpc = '0, pc;
    logic [31:0] imem_rdata = '0, inst;
    logic        dec_inval = 0, dec_ebreak = 0, dec_mem = 0, dec_jump = 0, dec_wen = 0;
    logic        rf_wen, halt, trap;
    logic [1:0]  trap_cause;
    logic [63:0] instret;

    localparam logic [63:0] RPC = 64'h8000_0000;

    always #5 clk = ~clk;

    exu_sequencer dut (
        .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
        .imem_rdata(imem_rdata), .inst(inst), .dec_inval(dec_inval), .dec_ebreak(dec_ebreak),
        .dec_mem(dec_mem), .dec_jump(dec_jump), .dec_wen(dec_wen), .exu_dnpc(exu_dnpc),
        .dmem_req(dmem_req), .dmem_ack(dmem_ack), .rf_wen(rf_wen), .pc(pc), .halt(halt),
        .trap(trap), .trap_cause(trap_cause), .instret(instret)
    );

    // kind: 0 retire, 1 halt, 2 trap
    typedef struct {
        int          kind;
        logic [63:0] pc;
        logic [63:0] ir;
        logic [1:0]  cause;
        logic        wen;
    } exp_t;
    exp_t sbq[$];

    int tests = 0, fails = 0;
    int ncyc = 0, last_ret = 0, ret_gap = 0, rf_cnt = 0, dreq_cnt = 0, ireq_cnt = 0;
    logic        p_halt = 0, p_trap = 0, p_rf = 0;
    logic [63:0] p_ir = '0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic push(input int k, input logic [63:0] p, input logic [63:0] ir,
                        input logic [1:0] c, input logic w);
        exp_t e;
        e.kind = k; e.pc = p; e.ir = ir; e.cause = c; e.wen = w;
        sbq.push_back(e);
    endtask

    always @(negedge clk) begin
        exp_t e;
        int   k;
        ncyc++;
        if (rst && ((halt && !p_halt) || (trap && !p_trap) || (!halt && instret == p_ir + 64'd1))) begin
            k = (halt && !p_halt) ? 1 : (trap && !p_trap) ? 2 : 0;
            if (sbq.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_event: kind %0d at pc %h, none expected", k, pc);
            end else begin
                e = sbq.pop_front();
                chk("event_kind", 64'(k), 64'(e.kind));
                chk("event_pc", pc, e.pc);
                chk("event_instret", instret, e.ir);
                if (k == 2) chk("trap_cause", 64'(trap_cause), 64'(e.cause));
                if (k == 0) begin
                    chk("wb_rf_wen", 64'(p_rf), 64'(e.wen));
                    ret_gap  = ncyc - last_ret;
                    last_ret = ncyc;
                end
            end
        end
        if (rf_wen) rf_cnt++;
        if (dmem_req) dreq_cnt++;
        if (imem_req) ireq_cnt++;
        p_halt = halt;
        p_trap = trap;
        p_rf   = rf_wen;
        p_ir   = instret;
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    // dw==0 leaves the data access pending and returns once dmem_req is seen
    task automatic issue(input logic [31:0] ins, input logic [63:0] addr, input int iw,
                         input bit inval, input bit eb, input bit mem, input bit jmp,
                         input bit wen, input logic [63:0] dnpc, input int dw);
        int n = 0;
        while (!imem_req && n < 50) begin @(negedge clk); n++; end
        if (!imem_req) begin
            tests++; fails++;
            $display("FAIL fetch_req: imem_req=0 after %0d cycles, expected 1", n);
            return;
        end
        chk("imem_addr", imem_addr, addr);
        repeat (iw) @(negedge clk);
        imem_ack = 1'b1; imem_rdata = ins;
        dec_inval = inval; dec_ebreak = eb; dec_mem = mem; dec_jump = jmp; dec_wen = wen;
        exu_dnpc = dnpc;
        @(negedge clk);
        imem_ack = 1'b0;
        chk("inst_latch", 64'(inst), 64'(ins));
        if (mem) begin
            n = 0;
            while (!dmem_req && n < 20) begin @(negedge clk); n++; end
            if (!dmem_req) begin
                tests++; fails++;
                $display("FAIL dmem_req: dmem_req=0 after %0d cycles, expected 1", n);
                return;
            end
            if (dw > 0) begin
                repeat (dw - 1) @(negedge clk);
                dmem_ack = 1'b1;
                @(negedge clk);
                dmem_ack = 1'b0;
            end
        end
    endtask

    task automatic drain();
        int n = 0;
        while (sbq.size() != 0 && n < 600) begin @(negedge clk); n++; end
        if (sbq.size() != 0) begin
            tests++; fails++;
            $display("FAIL drain: %0d expected events never appeared", sbq.size());
            sbq.delete();
        end
        @(negedge clk);
        #1;
    endtask

    initial begin
        int c0, c1;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        chk("rst_pc", pc, RPC);
        chk("rst_imem_req", 64'(imem_req), 0);
        chk("rst_dmem_req", 64'(dmem_req), 0);
        chk("rst_rf_wen", 64'(rf_wen), 0);
        chk("rst_halt", 64'(halt), 0);
        chk("rst_trap", 64'(trap), 0);
        chk("rst_cause", 64'(trap_cause), 0);
        chk("rst_instret", instret, 0);
        chk("rst_inst", 64'(inst), 0);

        // two zero-wait addi, the second with no rd write
        #1 c0 = rf_cnt;
        push(0, RPC + 4, 1, 0, 1);
        push(0, RPC + 8, 2, 0, 0);
        issue(32'h0010_0093, RPC, 0, 0, 0, 0, 0, 1, '0, 0);
        issue(32'h0000_0013, RPC + 4, 0, 0, 0, 0, 0, 0, '0, 0);
        drain();
        chk("cycles_per_inst", 64'(ret_gap), 4);
        chk("rf_wen_pulses", 64'(rf_cnt - c0), 1);

        // jalr to an odd target: bit0 dropped
        push(0, 64'h8000_0100, 3, 0, 1);
        issue(32'h0000_80e7, RPC + 8, 0, 0, 0, 0, 1, 1, 64'h8000_0101, 0);
        drain();

        // store with a 5-cycle data ack
        c0 = dreq_cnt;
        push(0, 64'h8000_0104, 4, 0, 0);
        issue(32'h0020_a023, 64'h8000_0100, 2, 0, 0, 1, 0, 0, '0, 5);
        drain();
        chk("dmem_req_cycles", 64'(dreq_cnt - c0), 5);

        // jalr to a target with bit1 set traps and never writes rd
        c0 = rf_cnt;
        push(2, 64'h8000_0104, 4, 2, 0);
        issue(32'h0000_80e7, 64'h8000_0104, 0, 0, 0, 0, 1, 1, 64'h8000_0202, 0);
        drain();
        repeat (5) @(negedge clk);
        #1;
        chk("misalign_no_wen", 64'(rf_cnt - c0), 0);
        chk("misalign_trap", 64'(trap), 1);
        chk("misalign_imem_req", 64'(imem_req), 0);
        chk("misalign_pc", pc, 64'h8000_0104);

        // fetch ack on the last allowed wait cycle, then ebreak halts
        do_reset();
        push(1, RPC, 1, 0, 0);
        issue(32'h0010_0073, RPC, 255, 0, 1, 0, 0, 0, '0, 0);
        drain();
        c0 = ireq_cnt;
        repeat (10) @(negedge clk);
        #1;
        chk("halt_no_fetch", 64'(ireq_cnt - c0), 0);
        chk("halt_sticky", 64'(halt), 1);
        chk("halt_pc", pc, RPC);

        // reset from HALT, then the fetch is never acked
        do_reset();
        chk("halt_rst_halt", 64'(halt), 0);
        chk("halt_rst_instret", instret, 0);
        #1 c0 = ireq_cnt;
        push(2, RPC, 0, 3, 0);
        drain();
        chk("timeout_req_cycles", 64'(ireq_cnt - c0), 256);
        chk("timeout_imem_req", 64'(imem_req), 0);

        // illegal instruction, alone and together with ebreak
        do_reset();
        push(2, RPC, 0, 1, 0);
        issue(32'hffff_ffff, RPC, 1, 1, 0, 0, 0, 1, '0, 0);
        drain();
        do_reset();
        push(2, RPC, 0, 1, 0);
        issue(32'h0010_0073, RPC, 0, 1, 1, 0, 0, 0, '0, 0);
        drain();
        chk("inval_over_ebreak_halt", 64'(halt), 0);

        // reset while a data access is pending
        do_reset();
        push(0, RPC + 4, 1, 0, 1);
        issue(32'h0010_0093, RPC, 0, 0, 0, 0, 0, 1, '0, 0);
        issue(32'h0020_a023, RPC + 4, 0, 0, 0, 1, 0, 0, '0, 0);
        chk("mem_pending_req", 64'(dmem_req), 1);
        rst = 1'b0;
        @(negedge clk);
        chk("mem_rst_dmem_req", 64'(dmem_req), 0);
        chk("mem_rst_pc", pc, RPC);
        chk("mem_rst_instret", instret, 0);
        chk("mem_rst_imem_req", 64'(imem_req), 0);
        rst = 1'b1;
        c1 = 0;
        push(0, RPC + 4, 1, 0, 1);
        issue(32'h0010_0093, RPC, 0, 0, 0, 0, 0, 1, '0, 0);
        drain();
        chk("scoreboard_empty", 64'(sbq.size()), 64'(c1));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run", tests);
        $fatal(1, "watchdog");
    end
endmodule
